fd_circle_window: RTL and testbench



---
 rtl/fd_pkg.sv | 21 ++
 rtl/fd_line_buffer.sv | 25 ++
 rtl/fd_circle_window.sv | 166 ++++++++++++++++
 tb/tb_fd_circle_window.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types and constants for the FAST-9 circle window front end:
// FSM state encoding, pixel/circle sizes and the radius-3 circle tap table.
package fd_pkg;

    localparam int PIX_W    = 8;
    localparam int CIRCLE_N = 16;
    localparam int WIN      = 7;
    localparam int LB_ROWS  = WIN - 1;
    localparam int CTR      = WIN / 2;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } fd_state_e;

    // Bresenham circle p0..p15, clockwise from straight up, offsets from the centre.
    localparam int CIRCLE_DX [CIRCLE_N] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CIRCLE_DY [CIRCLE_N] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

endpackage

// File: rtl/fd_line_buffer.sv
// Six-row line buffer stored as one wide word per column: combinational
// read with write on the same address, so a read returns the pre-write contents.
module fd_line_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/fd_circle_window.sv
// Raster-stream 7x7 window that emits each interior centre pixel with its 16
// radius-3 circle neighbours. Optional outLast flag under FD_WINDOW_LAST_EN.
module fd_circle_window
    import fd_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int COORD_W    = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PIX_W-1:0]          pixIn,
    input  logic                      pixValid,
    output logic                      pixReady,
    output logic [PIX_W-1:0]          refPixel,
    output logic [CIRCLE_N*PIX_W-1:0] adjPixel,
    output logic [COORD_W-1:0]        centerX,
    output logic [COORD_W-1:0]        centerY,
    output logic                      outValid,
    input  logic                      outReady,
    output logic                      frameDone,
`ifdef FD_WINDOW_LAST_EN
    output logic                      outLast,
`endif
    output fd_state_e                 dbgState
);

    localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int LB_W  = LB_ROWS * PIX_W;
    localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW   = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] FILL_ROW   = COORD_W'(WIN - 2);
    localparam logic [COORD_W-1:0] FIRST_EMIT = COORD_W'(WIN - 1);
    localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);
    localparam logic [COORD_W-1:0] HALF       = COORD_W'(CTR);

    fd_state_e                 r_state;
    logic [COORD_W-1:0]        r_col;
    logic [COORD_W-1:0]        r_row;
    logic [PIX_W-1:0]          r_win [WIN][WIN];
    logic [PIX_W-1:0]          w_win [WIN][WIN];
    logic [LB_W-1:0]           w_lb_rd;
    logic [LB_W-1:0]           w_lb_wr;
    logic                      w_accept;
    logic                      w_emit;
    logic                      w_last_col;
    logic                      w_last_pix;
    logic [PIX_W-1:0]          w_ref;
    logic [CIRCLE_N*PIX_W-1:0] w_adj;

    assign pixReady   = (r_state != ST_DONE) && (!outValid || outReady);
    assign w_accept   = pixValid && pixReady;
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_pix = w_last_col && (r_row == LAST_ROW);
    // STREAM implies row >= 6; the column gate keeps stale left columns out.
    assign w_emit     = w_accept && (r_state == ST_STREAM) && (r_col >= FIRST_EMIT);
    assign dbgState   = r_state;

    // Slot k holds row (r-6+k); shifting drops the oldest row and appends pixIn.
    assign w_lb_wr = {pixIn, w_lb_rd[LB_W-1:PIX_W]};

    fd_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (LB_AW),
        .DATA_W (LB_W)
    ) u_line_buffer (
        .clk     (clk),
        .i_en    (w_accept),
        .i_addr  (r_col[LB_AW-1:0]),
        .i_wdata (w_lb_wr),
        .o_rdata (w_lb_rd)
    );

    // Window as it will be after this cycle; row 0 is the oldest, column 6 the newest.
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                w_win[r][c] = r_win[r][c];
            end
        end
        if (w_accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    w_win[r][c] = r_win[r][c+1];
                end
            end
            for (int k = 0; k < LB_ROWS; k++) begin
                w_win[k][WIN-1] = w_lb_rd[k*PIX_W +: PIX_W];
            end
            w_win[WIN-1][WIN-1] = pixIn;
        end
    end

    always_comb begin
        w_ref = w_win[CTR][CTR];
        w_adj = '0;
        for (int i = 0; i < CIRCLE_N; i++) begin
            w_adj[(CIRCLE_N-1-i)*PIX_W +: PIX_W] = w_win[CTR + CIRCLE_DY[i]][CTR + CIRCLE_DX[i]];
        end
    end

    always_ff @(posedge clk) begin
        r_win <= w_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FILL;
            r_col     <= '0;
            r_row     <= '0;
            outValid  <= 1'b0;
            refPixel  <= '0;
            adjPixel  <= '0;
            centerX   <= '0;
            centerY   <= '0;
            frameDone <= 1'b0;
`ifdef FD_WINDOW_LAST_EN
            outLast   <= 1'b0;
`endif
        end else begin
            frameDone <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept && w_last_col && (r_row == FILL_ROW)) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept && w_last_pix) begin
                        r_state   <= ST_DONE;
                        frameDone <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_FILL;
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase

            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_ROW) ? '0 : r_row + ONE;
                end else begin
                    r_col <= r_col + ONE;
                end
            end

            if (w_emit) begin
                outValid <= 1'b1;
                refPixel <= w_ref;
                adjPixel <= w_adj;
                centerX  <= r_col - HALF;
                centerY  <= r_row - HALF;
`ifdef FD_WINDOW_LAST_EN
                outLast  <= w_last_pix;
`endif
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fd_circle_window.sv
// Directed bench for fd_circle_window on a 16x16 ramp image (pixel = 16*y + x),
// covering free flow, output backpressure, sparse input, two frames and mid-frame reset.
module tb_fd_circle_window;
    import fd_pkg::*;

    localparam int W     = 16;
    localparam int H     = 16;
    localparam int CW    = 10;
    localparam int REC_W = 1 + CW + CW + 8 + 128;
    localparam int TB_DX [16] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int TB_DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    logic           clk;
    logic           reset;
    logic [7:0]     pixIn;
    logic           pixValid;
    logic           pixReady;
    logic [7:0]     refPixel;
    logic [127:0]   adjPixel;
    logic [CW-1:0]  centerX;
    logic [CW-1:0]  centerY;
    logic           outValid;
    logic           outReady;
    logic           frameDone;
    logic           obs_last;
    fd_state_e      dbgState;

    fd_circle_window #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COORD_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixIn     (pixIn),
        .pixValid  (pixValid),
        .pixReady  (pixReady),
        .refPixel  (refPixel),
        .adjPixel  (adjPixel),
        .centerX   (centerX),
        .centerY   (centerY),
        .outValid  (outValid),
        .outReady  (outReady),
        .frameDone (frameDone),
`ifdef FD_WINDOW_LAST_EN
        .outLast   (obs_last),
`endif
        .dbgState  (dbgState)
    );

`ifndef FD_WINDOW_LAST_EN
    assign obs_last = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state.
    logic [REC_W-1:0] exp_q [$];
    logic             exp_ov;
    logic             exp_done;
    int               x, y;
    int               n_assert, n_fail;
    int               n_out, n_done, cyc;
    int               mark_out, pick_idx;
    logic [REC_W-1:0] first_obs, pick_obs, last_obs;

    function automatic logic [REC_W-1:0] make_rec(input int cx, input int cy);
        logic [127:0] adj;
        logic         lst;
        for (int i = 0; i < 16; i++) begin
            adj[(15-i)*8 +: 8] = 8'(16 * (cy + TB_DY[i]) + cx + TB_DX[i]);
        end
`ifdef FD_WINDOW_LAST_EN
        lst = (cx == W - 4) && (cy == H - 4);
`else
        lst = 1'b0;
`endif
        return {lst, CW'(cy), CW'(cx), 8'(16 * cy + cx), adj};
    endfunction

    function automatic logic [REC_W-1:0] obs_rec();
        return {obs_last, centerY, centerX, refPixel, adjPixel};
    endfunction

    task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic rdy, output logic acc);
        logic             exp_pr;
        logic             hs;
        logic             nxt_ov;
        logic             nxt_done;
        fd_state_e        exp_st;
        logic [REC_W-1:0] obs;
        pixValid = v;
        pixIn    = 8'(16 * y + x);
        outReady = rdy;
        #1;
        exp_pr = !exp_done && !(exp_ov && !rdy);
        exp_st = exp_done ? ST_DONE : ((y >= 6) ? ST_STREAM : ST_FILL);
        obs    = obs_rec();
        chk("outValid", outValid, exp_ov);
        chk("frameDone", frameDone, exp_done);
        chk("pixReady", pixReady, exp_pr);
        chk("state", dbgState, exp_st);
        if (exp_ov) begin
            chk("out_data", obs, exp_q[0]);
        end
        acc = v && exp_pr;
        hs  = exp_ov && rdy;
        nxt_ov   = exp_ov;
        nxt_done = 1'b0;
        if (hs) begin
            if (n_out == mark_out) first_obs = obs;
            if (n_out == mark_out + pick_idx) pick_obs = obs;
            last_obs = obs;
            n_out++;
            void'(exp_q.pop_front());
            nxt_ov = 1'b0;
        end
        if (exp_done) n_done++;
        if (acc) begin
            if (x >= 6 && y >= 6) begin
                exp_q.push_back(make_rec(x - 3, y - 3));
                nxt_ov = 1'b1;
            end
            if (x == W - 1 && y == H - 1) nxt_done = 1'b1;
            if (x == W - 1) begin
                x = 0;
                y = (y == H - 1) ? 0 : y + 1;
            end else begin
                x = x + 1;
            end
        end
        exp_ov   = nxt_ov;
        exp_done = nxt_done;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: free flow, 1: outReady 1-on/2-off, 2: pixValid random 50%.
    task automatic run_pixels(input int n_pix, input int mode);
        int   got;
        int   budget;
        logic v, rdy, a;
        got    = 0;
        budget = 0;
        while (got < n_pix && budget < 3000) begin
            v   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            cycle(v, rdy, a);
            if (a) got++;
            budget++;
        end
        chk("pixel_budget", budget < 3000, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, a);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pixValid = 1'b0;
        outReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ov   = 1'b0;
        exp_done = 1'b0;
        x = 0;
        y = 0;
        #1;
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_pixReady", pixReady, 1'b1);
        chk("rst_frameDone", frameDone, 1'b0);
        chk("rst_state", dbgState, ST_FILL);
    endtask

    initial begin
        int o0, d0;
        reset = 1'b1; pixValid = 1'b0; pixIn = '0; outReady = 1'b0;
        exp_ov = 1'b0; exp_done = 1'b0; x = 0; y = 0;
        n_assert = 0; n_fail = 0; n_out = 0; n_done = 0; cyc = 0;
        mark_out = 0; pick_idx = 99;
        first_obs = '0; pick_obs = '0; last_obs = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_pixReady", pixReady, 1'b1);
        chk("rst_frameDone", frameDone, 1'b0);
        chk("rst_refPixel", refPixel, 8'd0);
        chk("rst_adjPixel", adjPixel, 128'd0);
        chk("rst_centerX", centerX, 10'd0);
        chk("rst_centerY", centerY, 10'd0);
        chk("rst_outLast", obs_last, 1'b0);
        chk("rst_state", dbgState, ST_FILL);

        // Free-flow ramp frame with spot checks on the first and last centres.
        o0 = n_out; d0 = n_done; mark_out = n_out; pick_idx = 99;
        run_pixels(W * H, 0);
        chk("f1_count", n_out - o0, 100);
        chk("f1_done", n_done - d0, 1);
        chk("f1_first_xy", {first_obs[155:146], first_obs[145:136]}, {10'd3, 10'd3});
        chk("f1_first_ref", first_obs[135:128], 8'd51);
        chk("f1_first_p0", first_obs[127:120], 8'd3);
        chk("f1_first_p4", first_obs[95:88], 8'd54);
        chk("f1_first_p8", first_obs[63:56], 8'd99);
        chk("f1_first_p12", first_obs[31:24], 8'd48);
        chk("f1_last_xy", {last_obs[155:146], last_obs[145:136]}, {10'd12, 10'd12});
        chk("f1_last_ref", last_obs[135:128], 8'd204);
`ifdef FD_WINDOW_LAST_EN
        chk("f1_last_flag", last_obs[156], 1'b1);
        chk("f1_first_flag", first_obs[156], 1'b0);
`endif

        // Output backpressure.
        o0 = n_out; d0 = n_done;
        run_pixels(W * H, 1);
        chk("bp_count", n_out - o0, 100);
        chk("bp_done", n_done - d0, 1);

        // Sparse input.
        o0 = n_out; d0 = n_done;
        run_pixels(W * H, 2);
        chk("sparse_count", n_out - o0, 100);
        chk("sparse_done", n_done - d0, 1);

        // Two back-to-back frames; second frame restarts at centre (3,3).
        o0 = n_out; d0 = n_done; mark_out = n_out; pick_idx = 100;
        run_pixels(2 * W * H, 0);
        chk("b2b_count", n_out - o0, 200);
        chk("b2b_done", n_done - d0, 2);
        chk("b2b_f2_first_xy", {pick_obs[155:146], pick_obs[145:136]}, {10'd3, 10'd3});
        chk("b2b_f2_last_xy", {last_obs[155:146], last_obs[145:136]}, {10'd12, 10'd12});

        // Mid-frame reset after 100 pixels, then a full frame.
        run_pixels(100, 0);
        do_reset();
        o0 = n_out; d0 = n_done;
        run_pixels(W * H, 0);
        chk("rst_frame_count", n_out - o0, 100);
        chk("rst_frame_done", n_done - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
